// File: rtl/keypad_entry_unit.sv
// Keypad front end: 4x4 matrix scan, per-sweep debounce, decimal digit entry
// with sign, and a saturated {operand, opcode} token over valid/ready.
module keypad_entry_unit #(
  parameter int DIGITS   = 3,
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                row_n,
  output logic [3:0]                col,
  output logic                      tok_valid,
  input  logic                      tok_ready,
  output logic signed [WIDTH-1:0]   tok_operand,
  output logic [2:0]                tok_op,
  output logic                      tok_ovf,
  output logic                      tok_empty,
  output logic [DIGITS*4-1:0]       entry_bcd,
  output logic                      entry_neg,
  output logic [2:0]                digit_cnt,
  output logic                      key_drop
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MAG_W = $clog2(10 ** DIGITS);
  localparam int CW    = ((MAG_W > WIDTH) ? MAG_W : WIDTH) + 1;
  localparam int BCD_W = DIGITS * 4;

  typedef enum logic {S_IDLE, S_HELD} db_state_t;

  function automatic logic [1:0] row_of(input logic [3:0] h);
    if (h[0])      return 2'd0;
    else if (h[1]) return 2'd1;
    else if (h[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Returns {ovf, operand}; the negative range reaches one step further than the positive.
  function automatic logic [WIDTH:0] saturate(input logic [MAG_W-1:0] m, input logic neg);
    logic [CW-1:0] mw;
    logic [CW-1:0] lim;
    mw  = CW'(m);
    lim = CW'(1) << (WIDTH - 1);
    if (!neg) begin
      if (mw >= lim) return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
      else           return {1'b0, mw[WIDTH-1:0]};
    end else begin
      if (mw > lim)  return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
      else           return {1'b0, WIDTH'(CW'(0) - mw)};
    end
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       row_s1, row_s2;
  logic [1:0]       col_idx;
  logic [1:0]       acc_n;
  logic [3:0]       acc_code;
  logic [3:0]       hits;
  logic [2:0]       hit_n;
  logic [2:0]       tot_raw;
  logic [1:0]       tot_n;
  logic [3:0]       new_code;

  assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign col  = 4'b0001 << col_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      row_s1  <= 4'hF;
      row_s2  <= 4'hF;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      row_s1  <= row_n;
      row_s2  <= row_s1;
    end
  end

  always_comb begin
    hits     = ~row_s2;
    hit_n    = 3'($countones(hits));
    tot_raw  = {1'b0, acc_n} + hit_n;
    tot_n    = (tot_raw >= 3'd2) ? 2'd2 : tot_raw[1:0];
    new_code = (acc_n == 2'd0 && hit_n == 3'd1) ? {row_of(hits), col_idx} : acc_code;
  end

  // Stage p0: sweep result, one pulse per four scan ticks
  logic       vld_p0;
  logic       sweep_key_p0;
  logic [3:0] sweep_code_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_idx       <= 2'd0;
      acc_n         <= 2'd0;
      acc_code      <= 4'd0;
      vld_p0        <= 1'b0;
      sweep_key_p0  <= 1'b0;
      sweep_code_p0 <= 4'd0;
    end else begin
      vld_p0 <= 1'b0;
      if (tick) begin
        col_idx <= col_idx + 2'd1;
        if (col_idx == 2'd3) begin
          vld_p0        <= 1'b1;
          sweep_key_p0  <= (tot_n == 2'd1);
          sweep_code_p0 <= new_code;
          acc_n         <= 2'd0;
          acc_code      <= 4'd0;
        end else begin
          acc_n    <= tot_n;
          acc_code <= new_code;
        end
      end
    end
  end

  db_state_t  state_q, state_d;
  logic [3:0] db_cnt_q, db_cnt_d, db_cnt_n;
  logic [3:0] cand_q, cand_d;
  logic       evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      db_cnt_q <= 4'd0;
      cand_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      cand_q   <= cand_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    cand_d   = cand_q;
    db_cnt_n = 4'd0;
    evt      = 1'b0;
    if (vld_p0) begin
      case (state_q)
        S_IDLE: begin
          if (sweep_key_p0) begin
            db_cnt_n = (db_cnt_q != 4'd0 && sweep_code_p0 == cand_q) ? 4'(db_cnt_q + 4'd1) : 4'd1;
            cand_d   = sweep_code_p0;
            if (db_cnt_n == 4'(DEBOUNCE)) begin
              evt      = 1'b1;
              state_d  = S_HELD;
              db_cnt_d = 4'd0;
            end else begin
              db_cnt_d = db_cnt_n;
            end
          end else begin
            db_cnt_d = 4'd0;
          end
        end
        S_HELD: begin
          if (!sweep_key_p0) begin
            db_cnt_n = 4'(db_cnt_q + 4'd1);
            if (db_cnt_n == 4'(DEBOUNCE)) begin
              state_d  = S_IDLE;
              db_cnt_d = 4'd0;
            end else begin
              db_cnt_d = db_cnt_n;
            end
          end else begin
            db_cnt_d = 4'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Stage p1: debounced key event
  logic       vld_p1;
  logic [3:0] key_code_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      key_code_p1 <= 4'd0;
    end else begin
      vld_p1 <= evt;
      if (evt) key_code_p1 <= sweep_code_p0;
    end
  end

  logic       is_dig, is_sign, is_op;
  logic [3:0] dig;
  logic [2:0] op_code;
  logic [1:0] k_row, k_col;

  always_comb begin
    k_row   = key_code_p1[3:2];
    k_col   = key_code_p1[1:0];
    is_dig  = 1'b0;
    is_sign = 1'b0;
    is_op   = 1'b0;
    dig     = 4'd0;
    op_code = 3'd0;
    if (k_col == 2'd3) begin
      is_op   = 1'b1;
      op_code = (k_row == 2'd3) ? 3'd3 : {1'b0, k_row};
    end else if (k_row == 2'd3) begin
      case (k_col)
        2'd0:    is_sign = 1'b1;
        2'd1:    is_dig  = 1'b1;
        default: begin is_op = 1'b1; op_code = 3'd4; end
      endcase
    end else begin
      is_dig = 1'b1;
      dig    = 4'(4'(k_row) * 4'd3 + 4'(k_col) + 4'd1);
    end
  end

  // Stage p2: operand entry and token register
  logic [MAG_W-1:0] mag;
  logic [WIDTH:0]   sat_res;

  assign sat_res = saturate(mag, entry_neg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok_valid   <= 1'b0;
      tok_operand <= '0;
      tok_op      <= 3'd0;
      tok_ovf     <= 1'b0;
      tok_empty   <= 1'b0;
      entry_bcd   <= '0;
      entry_neg   <= 1'b0;
      digit_cnt   <= 3'd0;
      mag         <= '0;
      key_drop    <= 1'b0;
    end else begin
      key_drop <= 1'b0;
      if (tok_valid && tok_ready) begin
        tok_valid <= 1'b0;
        entry_bcd <= '0;
        entry_neg <= 1'b0;
        digit_cnt <= 3'd0;
        mag       <= '0;
      end
      if (vld_p1) begin
        if (tok_valid) begin
          key_drop <= 1'b1;
        end else if (is_dig) begin
          if (digit_cnt < 3'(DIGITS)) begin
            entry_bcd <= (entry_bcd << 4) | BCD_W'(dig);
            mag       <= MAG_W'(mag * MAG_W'(10)) + MAG_W'(dig);
            digit_cnt <= digit_cnt + 3'd1;
          end
        end else if (is_sign) begin
          entry_neg <= ~entry_neg;
        end else if (is_op) begin
          tok_valid   <= 1'b1;
          tok_op      <= op_code;
          tok_empty   <= (digit_cnt == 3'd0);
          tok_ovf     <= sat_res[WIDTH];
          tok_operand <= sat_res[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_unit.sv
// Directed bench for keypad_entry_unit: a behavioural keypad drives row_n from col,
// presses are long holds, and tokens are captured as they appear.
module tb_keypad_entry_unit;

  localparam int DIGITS   = 3;
  localparam int WIDTH    = 8;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 4;
  localparam int SWEEP    = 4 * SCAN_DIV;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [3:0]              row_n;
  logic [3:0]              col;
  logic                    tok_valid;
  logic                    tok_ready;
  logic signed [WIDTH-1:0] tok_operand;
  logic [2:0]              tok_op;
  logic                    tok_ovf;
  logic                    tok_empty;
  logic [DIGITS*4-1:0]     entry_bcd;
  logic                    entry_neg;
  logic [2:0]              digit_cnt;
  logic                    key_drop;

  keypad_entry_unit #(
    .DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .col(col),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_operand(tok_operand),
    .tok_op(tok_op), .tok_ovf(tok_ovf), .tok_empty(tok_empty),
    .entry_bcd(entry_bcd), .entry_neg(entry_neg), .digit_cnt(digit_cnt),
    .key_drop(key_drop)
  );

  always #5 clk = ~clk;

  // Pressed keys, bit index = row*4 + column
  logic [15:0] keys = 16'h0;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col[c]) row_n[r] = 1'b0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Token and drop monitor
  int         tok_count = 0;
  int         drop_count = 0;
  int         stab_err = 0;
  logic [7:0] cap_operand = 8'h0;
  logic [2:0] cap_op = 3'd0;
  logic       cap_ovf = 1'b0;
  logic       cap_empty = 1'b0;
  logic       prev_valid = 1'b0;
  logic [12:0] prev_fields = 13'h0;

  always @(negedge clk) begin
    if (key_drop) drop_count++;
    if (tok_valid && !prev_valid) begin
      tok_count++;
      cap_operand = tok_operand;
      cap_op      = tok_op;
      cap_ovf     = tok_ovf;
      cap_empty   = tok_empty;
    end
    if (tok_valid && prev_valid && prev_fields != {tok_operand, tok_op, tok_ovf, tok_empty})
      stab_err++;
    prev_valid  = tok_valid;
    prev_fields = {tok_operand, tok_op, tok_ovf, tok_empty};
  end

  function automatic int key_idx(input byte ch);
    case (ch)
      "1": return 0;  "2": return 1;  "3": return 2;  "A": return 3;
      "4": return 4;  "5": return 5;  "6": return 6;  "B": return 7;
      "7": return 8;  "8": return 9;  "9": return 10; "C": return 11;
      "E": return 12; "0": return 13; "F": return 14; default: return 15;
    endcase
  endfunction

  task automatic wait_sweeps(input int n);
    repeat (n * SWEEP) @(negedge clk);
  endtask

  task automatic hold(input byte ch, input int on_sweeps);
    keys = 16'h1 << key_idx(ch);
    wait_sweeps(on_sweeps);
    keys = 16'h0;
  endtask

  task automatic press(input byte ch);
    hold(ch, 8);
    wait_sweeps(8);
  endtask

  task automatic press_seq(input string s);
    for (int i = 0; i < s.len(); i++) press(s[i]);
  endtask

  task automatic check_tok(input string tag, input int exp_cnt, input logic [7:0] opnd,
                           input logic [2:0] op, input logic ovf, input logic empty);
    chk({tag, "_count"}, tok_count, exp_cnt);
    chk({tag, "_operand"}, cap_operand, opnd);
    chk({tag, "_op"}, cap_op, op);
    chk({tag, "_ovf"}, cap_ovf, ovf);
    chk({tag, "_empty"}, cap_empty, empty);
  endtask

  initial begin
    reset     = 1'b1;
    tok_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_col", col, 4'b0001);
    chk("rst_valid", tok_valid, 0);
    chk("rst_operand", tok_operand, 0);
    chk("rst_entry", entry_bcd, 0);
    chk("rst_cnt", digit_cnt, 0);
    chk("rst_drop", key_drop, 0);
    reset = 1'b0;

    // 1: basic positive operand
    press_seq("123");
    chk("t1_bcd", entry_bcd, 12'h123);
    chk("t1_cnt", digit_cnt, 3);
    press("A");
    check_tok("t1", 1, 8'h7B, 3'd0, 1'b0, 1'b0);
    chk("t1_clr_bcd", entry_bcd, 0);
    chk("t1_clr_cnt", digit_cnt, 0);

    // 2: sign, saturation, empty operand
    press("E");
    chk("t2_neg", entry_neg, 1);
    press_seq("128F");
    check_tok("t2a", 2, 8'h80, 3'd4, 1'b0, 1'b0);
    chk("t2a_neg_clr", entry_neg, 0);
    press_seq("200B");
    check_tok("t2b", 3, 8'h7F, 3'd1, 1'b1, 1'b0);
    press_seq("E200C");
    check_tok("t2c", 4, 8'h80, 3'd2, 1'b1, 1'b0);
    press("B");
    check_tok("t2d", 5, 8'h00, 3'd1, 1'b0, 1'b1);

    // 3: short press, bounce, long hold
    hold("7", 3);
    wait_sweeps(8);
    chk("t3_short", digit_cnt, 0);
    hold("7", 1);
    wait_sweeps(1);
    hold("7", 3);
    wait_sweeps(8);
    chk("t3_bounce", digit_cnt, 0);
    hold("7", 40);
    wait_sweeps(8);
    chk("t3_long_cnt", digit_cnt, 1);
    chk("t3_long_dig", entry_bcd[3:0], 4'h7);
    press("D");
    check_tok("t3", 6, 8'h07, 3'd3, 1'b0, 1'b0);

    // 4: backpressure and key_drop
    tok_ready = 1'b0;
    press_seq("1A");
    chk("t4_valid", tok_valid, 1);
    check_tok("t4a", 7, 8'h01, 3'd0, 1'b0, 1'b0);
    press("5");
    chk("t4_drop", drop_count, 1);
    chk("t4_bcd_hold", entry_bcd, 12'h001);
    chk("t4_operand_hold", tok_operand, 8'h01);
    chk("t4_stable", stab_err, 0);
    tok_ready = 1'b1;
    @(negedge clk);
    chk("t4_hs_valid", tok_valid, 0);
    chk("t4_hs_bcd", entry_bcd, 0);
    press("5");
    chk("t4_after_bcd", entry_bcd, 12'h005);
    press("A");
    check_tok("t4b", 8, 8'h05, 3'd0, 1'b0, 1'b0);

    // 5: digit limit and two-key rejection
    press_seq("1234");
    chk("t5_bcd", entry_bcd, 12'h123);
    chk("t5_cnt", digit_cnt, 3);
    chk("t5_nodrop", drop_count, 1);
    keys = (16'h1 << key_idx("1")) | (16'h1 << key_idx("5"));
    wait_sweeps(8);
    keys = 16'h0;
    wait_sweeps(8);
    chk("t5_two_keys", entry_bcd, 12'h123);
    press("F");
    check_tok("t5", 9, 8'h7B, 3'd4, 1'b0, 1'b0);

    // 6: asynchronous reset mid-debounce
    press_seq("42");
    chk("t6_pre_bcd", entry_bcd, 12'h042);
    keys = 16'h1 << key_idx("3");
    wait_sweeps(2);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_cnt", digit_cnt, 0);
    chk("t6_async_bcd", entry_bcd, 0);
    chk("t6_async_col", col, 4'b0001);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (56) @(negedge clk);
    chk("t6_early", digit_cnt, 0);
    repeat (24) @(negedge clk);
    chk("t6_late_cnt", digit_cnt, 1);
    chk("t6_late_bcd", entry_bcd, 12'h003);
    keys = 16'h0;
    wait_sweeps(8);
    chk("t6_drop_total", drop_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry_unit.md
Name: keypad_entry_unit

Overview:
Parametrised keypad front end for the calculator datapath: scans a 4x4 matrix keypad, debounces each key, and assembles up to DIGITS decimal digits plus a sign into a WIDTH-bit two's-complement operand. Operator and equals keys close the entry and emit one {operand, opcode} token over a valid/ready handshake to the ALU/sequencer. Adds what the previous generation lacked: a debounce filter, no auto-repeat, overflow saturation, a backpressure handshake, and digit/width generics.

Parameters:
DIGITS, 3, max decimal digits per operand (1..6)
WIDTH, 8, operand width, two's complement (4..24)
SCAN_DIV, 100000, clk cycles per scan tick (sim: 4)
DEBOUNCE, 4, consecutive full sweeps a key state must hold before it is accepted (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; clock clk
row_n  in  4  keypad rows, active-low
col  out  4  column drive, one-hot active-high
tok_valid  out  1  token available
tok_ready  in  1  consumer accepts token
tok_operand  out  WIDTH  signed operand (saturated)
tok_op  out  3  0 add(A),1 sub(B),2 mul(C),3 div(D),4 equ(F)
tok_ovf  out  1  magnitude exceeded signed range
tok_empty  out  1  no digits entered before operator
entry_bcd  out  DIGITS*4  digits typed so far, last digit in [3:0]
entry_neg  out  1  sign of current entry
digit_cnt  out  3  digits entered (0..DIGITS)
key_drop  out  1  1-cycle pulse, key event discarded

Behaviour:
- Reset (async): col=4'b0001, tok_valid=0, all token fields 0, entry_bcd=0, entry_neg=0, digit_cnt=0, key_drop=0, divider/debounce/accumulator=0.
- Tick: 1-cycle pulse every SCAN_DIV clk cycles. On each tick, sample ~row_n for the current column, then rotate col 0001->0010->0100->1000->0001. One sweep = 4 ticks.
- Sweep result: exactly one key seen -> 4-bit code; zero keys or more than one key -> NONE.
- Debounce FSM:
  - IDLE: a code seen for DEBOUNCE consecutive sweeps -> emit 1-cycle key event, go to HELD.
  - HELD: NONE for DEBOUNCE consecutive sweeps -> IDLE. No repeat while held.
  - A change of code during counting restarts the count.
- Key map:
  - row0: 1 2 3 A; row1: 4 5 6 B; row2: 7 8 9 C; row3: E 0 F D.
  - Row i maps to row_n[i]; column j maps to col[j].
- Digit event, digit_cnt<DIGITS: shift into entry_bcd; mag <= mag*10 + d (binary accumulator, ceil(log2(10^DIGITS)) bits); digit_cnt++.
- Digit event, digit_cnt==DIGITS: ignored, no drop pulse.
- E event: toggle entry_neg.
- Operator event (A-D, F): on the next cycle, tok_valid=1 with these fields:
  - tok_op per key map.
  - tok_empty = (digit_cnt==0).
  - Positive entry: mag > 2^(WIDTH-1)-1 -> operand = max, tok_ovf=1.
  - Negative entry: mag > 2^(WIDTH-1) -> operand = min, tok_ovf=1.
  - Otherwise operand = ±mag; -0 gives 0.
- Token fields are stable while tok_valid=1. The token is consumed on a clk edge with tok_valid&tok_ready. That same edge clears tok_valid, entry_bcd, entry_neg, digit_cnt and mag.
- Any key event while tok_valid=1 is discarded (even on the handshake cycle) and pulses key_drop for 1 cycle.
- tok_ready is ignored while tok_valid=0. Scanning and debounce run continuously, independent of the handshake.
- Reset mid-sweep or mid-debounce: everything returns to reset values immediately; a key still held after reset release needs a full DEBOUNCE period before it produces an event.

Test Plan:
(SCAN_DIV=4, DEBOUNCE=4, defaults otherwise; each press is held for 8 sweeps, then released for 8.)
1. Press 1,2,3,A; tok_ready=1 -> single token, tok_operand=8'h7B, tok_op=0, tok_ovf=0, tok_empty=0; entry then cleared.
2. E,1,2,8,F -> 8'h80, op=4, ovf=0. 2,0,0,B -> 8'h7F, op=1, ovf=1. E,2,0,0,C -> 8'h80, ovf=1.
3. Key 7 held 3 sweeps then released; next, 7 with a bounce glitch in sweep 2 -> no event for either. 7 held 40 sweeps -> exactly one digit (entry_bcd[3:0]=7).
4. tok_ready=0 after a token; press 5 -> key_drop pulse, entry_bcd unchanged, token fields stable. Raise tok_ready -> handshake, then 5 is accepted.
5. Digits 1,2,3,4 -> entry_bcd=12'h123, digit_cnt=3, no key_drop. Two keys (1 and 5) pressed together -> no event.
6. Assert reset mid-debounce with entry 4,2 -> outputs zero and col=0001 before the next clk edge. After release, the held key needs 4 sweeps to register.
